// File: rtl/fdiv_ctrl.sv
// Issue/return controller for a fixed-latency, non-stalling fdiv: tag pipe, credit-limited result FIFO.
// Optional divide-by-zero flag carried with each result when FDIV_DIVZERO_EN is defined.
module fdiv_ctrl #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned DEPTH   = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fdiv_a,
  output logic [31:0]      fdiv_b,
  output logic             fdiv_en,
  input  logic [31:0]      fdiv_c,
  input  logic             fdiv_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_dz,
  output logic             err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(DEPTH + LATENCY + 1);
  localparam int unsigned WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic                         warm_done;
  logic [WW-1:0]                warm_cnt;
  logic [LATENCY-1:0]           pv;
  logic [TAG_W-1:0]             ptag [LATENCY];
  logic [31:0]                  mem_data [DEPTH];
  logic [TAG_W-1:0]             mem_tag  [DEPTH];
  logic [PW-1:0]                wptr, rptr;
  logic [CW-1:0]                count;
  logic                         push, pop, full, empty;
  logic [SW-1:0]                inflight, occupancy;

  assign fdiv_a  = req_a;
  assign fdiv_b  = req_b;
  assign fdiv_en = req_valid && req_ready;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      inflight = inflight + SW'(pv[i]);
    end
  end

  // Credits cover both buffered and in-flight results, since fdiv cannot be stalled.
  assign occupancy = inflight + SW'(count);
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign req_ready = warm_done && !full && (occupancy < SW'(DEPTH));

  assign push      = pv[LATENCY-1];
  assign res_valid = !empty;
  assign pop       = res_valid && res_ready;
  assign res_data  = res_valid ? mem_data[rptr] : '0;
  assign res_tag   = res_valid ? mem_tag[rptr]  : '0;

  // fdiv has no reset, so its output strobe is untrustworthy for LATENCY cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      warm_done <= 1'b0;
      warm_cnt  <= '0;
    end else if (!warm_done) begin
      if (warm_cnt == WW'(LATENCY - 1)) warm_done <= 1'b1;
      else                              warm_cnt  <= warm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) ptag[i] <= '0;
    end else begin
      pv <= (pv << 1) | LATENCY'(fdiv_en);
      ptag[0] <= req_tag;
      for (int unsigned i = 1; i < LATENCY; i++) ptag[i] <= ptag[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wptr] <= fdiv_c;
      mem_tag[wptr]  <= ptag[LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                     err <= 1'b0;
    else if (warm_done && (fdiv_ready != push))    err <= 1'b1;
  end

`ifdef FDIV_DIVZERO_EN
  logic               dz_calc;
  logic [LATENCY-1:0] pdz;
  logic [DEPTH-1:0]   mem_dz;

  assign dz_calc = (req_b[30:23] == 8'd0) && (req_a[30:23] != 8'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pdz <= '0;
    else       pdz <= (pdz << 1) | LATENCY'(dz_calc);
  end

  always_ff @(posedge clk) begin
    if (push) mem_dz[wptr] <= pdz[LATENCY-1];
  end

  assign res_dz = res_valid && mem_dz[rptr];
`else
  assign res_dz = 1'b0;
`endif

endmodule

// File: tb/tb_fdiv_ctrl.sv
// Directed self-checking bench for fdiv_ctrl with a behavioural fixed-latency fdiv stub.
module tb_fdiv_ctrl;
  localparam int LAT = 4;
  localparam int TW  = 6;
  localparam int DEP = 6;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid = 1'b0, req_ready;
  logic [31:0]   req_a = '0, req_b = '0;
  logic [TW-1:0] req_tag = '0;
  logic [31:0]   fdiv_a, fdiv_b, fdiv_c;
  logic          fdiv_en, fdiv_ready;
  logic          res_valid, res_ready = 1'b0;
  logic [31:0]   res_data;
  logic [TW-1:0] res_tag;
  logic          res_dz, err;

  int n_cmp = 0;
  int n_bad = 0;
  logic force_rdy = 1'b0;
  logic [LAT-1:0] mv = '0;
  logic [31:0]    mc [LAT];
  logic           exp_dz;

  fdiv_ctrl #(.LATENCY(LAT), .TAG_W(TW), .DEPTH(DEP)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fdiv_a(fdiv_a), .fdiv_b(fdiv_b), .fdiv_en(fdiv_en),
    .fdiv_c(fdiv_c), .fdiv_ready(fdiv_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .res_dz(res_dz), .err(err)
  );

  always #5 clk = ~clk;

  function automatic real sp2real(input logic [31:0] x);
    real r;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    r = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return x[31] ? -r : r;
  endfunction

  function automatic logic [31:0] real2sp(input real q);
    logic [63:0] d;
    int e;
    d = $realtobits(q);
    if (d[62:52] == 11'd0)   return {d[63], 31'd0};
    if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, 23'd0};
    e = int'(d[62:52]) - 896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Unresettable fdiv stub: result and strobe appear LAT cycles after fdiv_en.
  always @(posedge clk) begin
    mv    <= {mv[LAT-2:0], fdiv_en};
    mc[0] <= real2sp(sp2real(fdiv_a) / sp2real(fdiv_b));
    for (int i = 1; i < LAT; i++) mc[i] <= mc[i-1];
  end
  assign fdiv_ready = mv[LAT-1] | force_rdy;
  assign fdiv_c     = mc[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    req_valid = 1'b1; req_a = 32'h40C00000; req_b = 32'h40000000; req_tag = 6'd3;
    rstn = 1'b0;
    repeat (2) tick();
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL rst_res_valid: got %b expected 0", res_valid); end
    n_cmp++; if (res_data !== 32'h0) begin n_bad++; $display("FAIL rst_res_data: got %h expected 0", res_data); end
    n_cmp++; if (res_tag !== 6'h0) begin n_bad++; $display("FAIL rst_res_tag: got %h expected 0", res_tag); end
    n_cmp++; if (res_dz !== 1'b0) begin n_bad++; $display("FAIL rst_res_dz: got %b expected 0", res_dz); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b expected 0", err); end
    n_cmp++; if (fdiv_en !== 1'b0) begin n_bad++; $display("FAIL rst_fdiv_en: got %b expected 0", fdiv_en); end
    req_valid = 1'b0;
    rstn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++;
      if (req_ready !== (k == 4)) begin
        n_bad++; $display("FAIL warmup_ready_%0d: got %b expected %b", k, req_ready, (k == 4));
      end
    end
  endtask

  task automatic test_single();
    int lat;
    res_ready = 1'b1;
    req_valid = 1'b1; req_a = 32'h40C00000; req_b = 32'h40000000; req_tag = 6'd5;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL single_issue_ready: got %b expected 1", req_ready); end
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (res_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
    n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL single_latency: got %0d expected 5", lat); end
    n_cmp++; if (res_data !== 32'h40400000) begin n_bad++; $display("FAIL single_data: got %h expected 40400000", res_data); end
    n_cmp++; if (res_tag !== 6'd5) begin n_bad++; $display("FAIL single_tag: got %0d expected 5", res_tag); end
    n_cmp++; if (res_dz !== 1'b0) begin n_bad++; $display("FAIL single_dz: got %b expected 0", res_dz); end
    tick();
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL single_popped: got %b expected 0", res_valid); end
  endtask

  task automatic test_streaming();
    logic [TW-1:0] qt[$];
    logic [31:0]   qd[$];
    logic [TW-1:0] et;
    logic [31:0]   ed;
    int sent = 0, got = 0, drops = 0, cyc = 0;
    res_ready = 1'b1;
    while ((sent < 20 || got < 20) && cyc < 200) begin
      if (res_valid === 1'b1) begin
        if (qt.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL stream_unexpected: got tag %0d expected none", res_tag);
        end else begin
          et = qt.pop_front(); ed = qd.pop_front();
          n_cmp++; if (res_tag !== et) begin n_bad++; $display("FAIL stream_tag: got %0d expected %0d", res_tag, et); end
          n_cmp++; if (res_data !== ed) begin n_bad++; $display("FAIL stream_data: got %h expected %h", res_data, ed); end
        end
        got++;
      end
      if (sent < 20) begin
        req_valid = 1'b1;
        req_tag   = TW'(sent);
        req_a     = 32'h40000000 | (32'(sent) << 16);
        req_b     = 32'h3F800000;
        if (req_ready === 1'b1) begin qt.push_back(req_tag); qd.push_back(req_a); sent++; end
        else drops++;
      end else begin
        req_valid = 1'b0;
      end
      tick(); cyc++;
    end
    req_valid = 1'b0;
    n_cmp++; if (drops != 0) begin n_bad++; $display("FAIL stream_ready_drops: got %0d expected 0", drops); end
    n_cmp++; if (got != 20) begin n_bad++; $display("FAIL stream_count: got %0d expected 20", got); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL stream_err: got %b expected 0", err); end
  endtask

  task automatic test_backpressure();
    logic [TW-1:0] qt[$];
    logic [31:0]   qd[$];
    logic [TW-1:0] et;
    logic [31:0]   ed;
    int acc = 0, got = 0, cyc = 0;
    idle(2);
    res_ready = 1'b0;
    for (int c = 0; c < 15; c++) begin
      req_valid = 1'b1;
      req_tag   = TW'(32 + acc);
      req_a     = 32'h3F800000 | (32'(acc) << 18);
      req_b     = 32'h3F800000;
      if (req_ready === 1'b1) begin qt.push_back(req_tag); qd.push_back(req_a); acc++; end
      tick();
    end
    req_valid = 1'b0;
    n_cmp++; if (acc != 6) begin n_bad++; $display("FAIL bp_accepted: got %0d expected 6", acc); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low: got %b expected 0", req_ready); end
    n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL bp_res_valid: got %b expected 1", res_valid); end
    res_ready = 1'b1;
    while (got < 6 && cyc < 30) begin
      if (res_valid === 1'b1 && qt.size() > 0) begin
        et = qt.pop_front(); ed = qd.pop_front();
        n_cmp++; if (res_tag !== et) begin n_bad++; $display("FAIL bp_tag: got %0d expected %0d", res_tag, et); end
        n_cmp++; if (res_data !== ed) begin n_bad++; $display("FAIL bp_data: got %h expected %h", res_data, ed); end
        got++;
      end
      tick(); cyc++;
    end
    n_cmp++; if (got != 6) begin n_bad++; $display("FAIL bp_drained: got %0d expected 6", got); end
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %b expected 0", res_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_back: got %b expected 1", req_ready); end
  endtask

  task automatic test_divzero();
    int cyc = 0;
    idle(1);
    res_ready = 1'b1;
    req_valid = 1'b1; req_a = 32'h3F800000; req_b = 32'h00000000; req_tag = 6'd9;
    tick();
    req_valid = 1'b0;
    while (res_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
`ifdef FDIV_DIVZERO_EN
    exp_dz = 1'b1;
`else
    exp_dz = 1'b0;
`endif
    n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL dz_valid: got %b expected 1", res_valid); end
    n_cmp++; if (res_tag !== 6'd9) begin n_bad++; $display("FAIL dz_tag: got %0d expected 9", res_tag); end
    n_cmp++; if (res_dz !== exp_dz) begin n_bad++; $display("FAIL dz_flag: got %b expected %b", res_dz, exp_dz); end
    n_cmp++; if (res_data !== 32'h7F800000) begin n_bad++; $display("FAIL dz_data: got %h expected 7f800000", res_data); end
    tick();
  endtask

  task automatic test_reset_midflight();
    int notready = 0, stale = 0;
    idle(2);
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_tag = TW'(16 + i);
      req_a = 32'h40400000; req_b = 32'h3F800000;
      if (req_ready !== 1'b1) notready++;
      tick();
    end
    req_valid = 1'b0;
    tick();
    n_cmp++; if (notready != 0) begin n_bad++; $display("FAIL mid_issue: got %0d refusals expected 0", notready); end
    n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL mid_buffered: got %b expected 1", res_valid); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b expected 0", res_valid); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready: got %b expected 0", req_ready); end
    n_cmp++; if (res_data !== 32'h0) begin n_bad++; $display("FAIL mid_rst_data: got %h expected 0", res_data); end
    tick();
    rstn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (res_valid !== 1'b0) stale++;
      n_cmp++;
      if (req_ready !== (k == 4)) begin
        n_bad++; $display("FAIL mid_warmup_%0d: got %b expected %b", k, req_ready, (k == 4));
      end
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      if (res_valid !== 1'b0) stale++;
    end
    n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL mid_stale: got %0d expected 0", stale); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL mid_err: got %b expected 0", err); end
  endtask

  task automatic test_mismatch();
    idle(8);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL mm_before: got %b expected 0", err); end
    force_rdy = 1'b1;
    tick();
    force_rdy = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL mm_set: got %b expected 1", err); end
    idle(5);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL mm_sticky: got %b expected 1", err); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL mm_reset: got %b expected 0", err); end
    tick();
    rstn = 1'b1;
    idle(6);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL mm_after: got %b expected 0", err); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_divzero();
    test_reset_midflight();
    test_mismatch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fdiv_ctrl.md
FDIV_CTRL -- requirements
Module: fdiv_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
  LATENCY, 4, fixed issue-to-result delay of the attached fdiv in cycles.
  TAG_W, 6, destination-tag width.
  DEPTH, 6, result-buffer entries; also the credit limit.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with ports as follows (name, direction, width, meaning):
  clk  in  1  rising-edge clock for all state.
  rstn  in  1  asynchronous active-low reset.
  req_valid  in  1  divide request present.
  req_ready  out  1  request accepted this cycle if req_valid is also high.
  req_a  in  32  dividend (IEEE single).
  req_b  in  32  divisor (IEEE single).
  req_tag  in  TAG_W  destination tag.
  fdiv_a  out  32  operand a to fdiv; combinational copy of req_a.
  fdiv_b  out  32  operand b to fdiv; combinational copy of req_b.
  fdiv_en  out  1  equals req_valid && req_ready.
  fdiv_c  in  32  fdiv result.
  fdiv_ready  in  1  fdiv result-valid strobe.
  res_valid  out  1  buffered result available.
  res_ready  in  1  consumer takes the result this cycle.
  res_data  out  32  quotient.
  res_tag  out  TAG_W  tag of res_data.
  res_dz  out  1  divide-by-zero flag of res_data.
  err  out  1  sticky fdiv_ready/tag-pipe mismatch.

Function
REQ-003 SHALL keep a LATENCY-stage shift pipe of {valid, tag, dz}; stage 0 loads {fdiv_en, req_tag, dz_calc} every cycle.
REQ-004 SHALL treat pipe stage LATENCY-1 valid as the only authority for result arrival; fdiv_c SHALL be written into the buffer in that cycle.
REQ-005 SHALL hold buffer entries {fdiv_c, tag, dz} in a DEPTH-entry FIFO; res_valid is high whenever the FIFO is not empty, and the head entry drives res_data, res_tag and res_dz.
REQ-006 SHALL pop the FIFO head when res_valid && res_ready; a simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-007 SHALL keep inflight = number of valid pipe stages (0..LATENCY).
REQ-008 SHALL drive req_ready = !warmup && (inflight + count < DEPTH), so that the FIFO never overflows; fdiv cannot stall, and a result is never dropped.
REQ-009 SHALL sustain 1 issue/cycle indefinitely while res_ready is held high, given DEPTH >= LATENCY+2.
REQ-010 SHALL have first-issue-to-res_valid latency LATENCY+1 cycles (LATENCY in fdiv, plus 1 FIFO write).
REQ-011 SHALL keep a warm-up counter of LATENCY cycles after reset release; during warm-up req_ready=0 and mismatch checking is masked (fdiv has no reset).
REQ-012 SHALL set err in any post-warm-up cycle where fdiv_ready != pipe stage LATENCY-1 valid; err clears only on reset.
REQ-013 SHALL wrap the FIFO read and write pointers modulo DEPTH; full = (count==DEPTH), empty = (count==0).

Reset
REQ-014 SHALL, on rstn low, immediately clear the pipe valids, FIFO count and pointers, err, and the warm-up-done flag; any in-flight operations are discarded.
REQ-015 SHALL hold outputs during and after reset at: req_ready=0, res_valid=0, res_data=0, res_tag=0, res_dz=0, err=0, fdiv_en=0.

Configuration
REQ-016 SHALL, with macro FDIV_DIVZERO_EN defined, compute dz_calc = (req_b[30:23]==0) && (req_a[30:23]!=0) at issue and carry it to res_dz.
REQ-017 SHALL, without FDIV_DIVZERO_EN, tie dz_calc and res_dz to 0 and omit the dz pipe/FIFO bits.

Verification
REQ-018 SHALL cover single op: a=0x40C00000, b=0x40000000, tag=5, res_ready=1 -> res_valid exactly 5 cycles after issue, res_data=0x40400000, res_tag=5.
REQ-019 SHALL cover streaming: 20 back-to-back requests with res_ready=1 -> req_ready never drops after warm-up, tags return in order, err=0.
REQ-020 SHALL cover backpressure: res_ready=0 with continuous req_valid -> exactly 6 ops accepted, req_ready=0 after that, no loss; raising res_ready drains all 6 in order.
REQ-021 SHALL cover divide-by-zero: a=0x3F800000, b=0x00000000, tag=9 -> res_dz=1 with the macro defined, res_dz=0 without it.
REQ-022 SHALL cover reset mid-flight: rstn pulsed low with 3 ops in flight and 2 buffered -> res_valid=0 immediately, req_ready=0 for 4 cycles after release, no stale results, err=0.
REQ-023 SHALL cover mismatch: force fdiv_ready=1 with no op in flight after warm-up -> err=1 next cycle and stays 1 until reset.
